// File: rtl/cluster_decoder.sv
`default_nettype none
// ============================================================================
// Module   : cluster_decoder
// Purpose  : Reconstructs the S-bit hit map from one frame of priority-encoded
//            clusters. A frame holds NCLUSTERS clusters, each an address plus
//            a (strips-1) count. One cluster is expanded and OR-ed into a
//            working map per clock, giving a fixed NCLUSTERS+1 edge latency
//            from the accepting edge to the result strobe.
//
// Ports    : clock4x        in   fabric clock, all logic on posedge
//            reset_n        in   asynchronous active-low reset
//            clusters_valid in   frame strobe, adr_in/cnt_in valid this cycle
//            adr_in         in   packed addresses, cluster i at [i*MXADRB +: MXADRB]
//            cnt_in         in   packed counts,    cluster i at [i*MXCNTB +: MXCNTB]
//            ready          out  high when a strobe will be accepted
//            vpfs_out       out  reconstructed hit map, held between frames
//            vpfs_valid     out  one-cycle pulse when vpfs_out/n_clusters update
//            n_clusters     out  number of valid clusters in the last frame
//            dropped        out  one-cycle pulse, strobe arrived while busy
//
// Revision : 1.0  initial release
// ============================================================================
module cluster_decoder #(
  parameter int MXSBITS   = 1536,
  parameter int MXADRB    = 11,
  parameter int MXCNTB    = 3,
  parameter int NCLUSTERS = 8
) (
  input  logic                        clock4x,
  input  logic                        reset_n,
  input  logic                        clusters_valid,
  input  logic [NCLUSTERS*MXADRB-1:0] adr_in,
  input  logic [NCLUSTERS*MXCNTB-1:0] cnt_in,
  output logic                        ready,
  output logic [MXSBITS-1:0]          vpfs_out,
  output logic                        vpfs_valid,
  output logic [3:0]                  n_clusters,
  output logic                        dropped
);

  // Index width for walking through the clusters of one frame.
  localparam int C_IDXW = (NCLUSTERS > 1) ? $clog2(NCLUSTERS) : 1;
  // One extra bit so adr+cnt can exceed the address range without wrapping.
  localparam int C_ENDW = MXADRB + 1;
  localparam logic [C_IDXW-1:0] C_LAST_IDX = C_IDXW'(NCLUSTERS - 1);

  // FSM encoding
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]                  state_q,  state_d;
  logic                        ready_q,  ready_d;
  logic [NCLUSTERS*MXADRB-1:0] adr_q,    adr_d;
  logic [NCLUSTERS*MXCNTB-1:0] cnt_q,    cnt_d;
  logic [MXSBITS-1:0]          map_q,    map_d;
  logic [3:0]                  count_q,  count_d;
  logic [C_IDXW-1:0]           idx_q,    idx_d;
  logic [MXSBITS-1:0]          vpfs_q,   vpfs_d;
  logic [3:0]                  ncl_q,    ncl_d;
  logic                        valid_q,  valid_d;
  logic                        dropped_q, dropped_d;

  // --------------------------------------------------------------------------
  // Expansion of the cluster currently selected by idx_q
  // --------------------------------------------------------------------------
  logic [MXADRB-1:0]  w_cur_adr;
  logic [MXCNTB-1:0]  w_cur_cnt;
  logic [C_ENDW-1:0]  w_end;
  logic               w_cl_valid;
  logic [MXSBITS-1:0] w_mask;

  assign w_cur_adr = adr_q[int'(idx_q)*MXADRB +: MXADRB];
  assign w_cur_cnt = cnt_q[int'(idx_q)*MXCNTB +: MXCNTB];

  // Addresses at or above the map size (including the all-ones "no cluster"
  // code) are empty slots.
  assign w_cl_valid = (C_ENDW'(w_cur_adr) < C_ENDW'(MXSBITS));
  assign w_end      = C_ENDW'(w_cur_adr) + C_ENDW'(w_cur_cnt);

  // Bit b is hit when adr <= b <= adr+cnt. Since b never exceeds MXSBITS-1,
  // a run that extends past the top of the map is clipped, never wrapped.
  always_comb begin
    w_mask = '0;
    for (int b = 0; b < MXSBITS; b++) begin
      w_mask[b] = w_cl_valid
                  && (C_ENDW'(b) >= C_ENDW'(w_cur_adr))
                  && (C_ENDW'(b) <= w_end);
    end
  end

  // --------------------------------------------------------------------------
  // Strobe handling. ready is a register, so a strobe on the same edge that
  // leaves DONE is still seen against ready=0 and dropped.
  // --------------------------------------------------------------------------
  logic w_accept;
  logic w_drop;

  assign w_accept = clusters_valid &&  ready_q;
  assign w_drop   = clusters_valid && !ready_q;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    ready_d   = ready_q;
    adr_d     = adr_q;
    cnt_d     = cnt_q;
    map_d     = map_q;
    count_d   = count_q;
    idx_d     = idx_q;
    vpfs_d    = vpfs_q;
    ncl_d     = ncl_q;
    valid_d   = 1'b0;
    dropped_d = w_drop;

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          adr_d   = adr_in;
          cnt_d   = cnt_in;
          map_d   = '0;
          count_d = '0;
          idx_d   = '0;
          ready_d = 1'b0;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        // OR-accumulation makes duplicate and overlapping clusters harmless.
        map_d = map_q | w_mask;
        if (w_cl_valid) begin
          count_d = count_q + 4'd1;
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == C_LAST_IDX) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        vpfs_d  = map_q;
        ncl_d   = count_q;
        valid_d = 1'b1;
        ready_d = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock4x or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      ready_q   <= 1'b1;
      adr_q     <= '0;
      cnt_q     <= '0;
      map_q     <= '0;
      count_q   <= '0;
      idx_q     <= '0;
      vpfs_q    <= '0;
      ncl_q     <= '0;
      valid_q   <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      adr_q     <= adr_d;
      cnt_q     <= cnt_d;
      map_q     <= map_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      vpfs_q    <= vpfs_d;
      ncl_q     <= ncl_d;
      valid_q   <= valid_d;
      dropped_q <= dropped_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign ready      = ready_q;
  assign vpfs_out   = vpfs_q;
  assign vpfs_valid = valid_q;
  assign n_clusters = ncl_q;
  assign dropped    = dropped_q;

endmodule
`default_nettype wire

// File: tb/tb_cluster_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cluster_decoder
// Purpose  : Directed self-checking bench for cluster_decoder. Each scenario
//            task drives a frame and compares outputs against hand-computed
//            hit maps, counts and latencies.
// Revision : 1.0  initial release
// ============================================================================
module tb_cluster_decoder;

  logic          clock4x;
  logic          reset_n;
  logic          clusters_valid;
  logic [87:0]   adr_in;
  logic [23:0]   cnt_in;
  logic          ready;
  logic [1535:0] vpfs_out;
  logic          vpfs_valid;
  logic [3:0]    n_clusters;
  logic          dropped;

  int n_cmp;
  int n_err;
  int drop_cnt;

  cluster_decoder #(
    .MXSBITS  (1536),
    .MXADRB   (11),
    .MXCNTB   (3),
    .NCLUSTERS(8)
  ) dut (
    .clock4x       (clock4x),
    .reset_n       (reset_n),
    .clusters_valid(clusters_valid),
    .adr_in        (adr_in),
    .cnt_in        (cnt_in),
    .ready         (ready),
    .vpfs_out      (vpfs_out),
    .vpfs_valid    (vpfs_valid),
    .n_clusters    (n_clusters),
    .dropped       (dropped)
  );

  initial clock4x = 1'b0;
  always #5 clock4x = ~clock4x;

  // Count dropped pulses, sampled mid-cycle.
  initial drop_cnt = 0;
  always @(negedge clock4x) begin
    if (dropped === 1'b1) drop_cnt++;
  end

  // All slots empty (0x7FF), counts zero.
  task automatic clear_frame();
    adr_in = '1;
    cnt_in = '0;
  endtask

  task automatic set_cl(input int i, input int a, input int c);
    adr_in[i*11 +: 11] = 11'(a);
    cnt_in[i*3 +: 3]   = 3'(c);
  endtask

  // Called just after a posedge with the DUT idle. Strobes the current
  // frame, returns ready as seen after the accepting edge and the number of
  // edges until vpfs_valid is seen (-1 if never within the budget).
  task automatic run_frame(output logic rdy_after, output int lat);
    bit found;
    clusters_valid = 1'b1;
    @(posedge clock4x); #1;
    clusters_valid = 1'b0;
    rdy_after = ready;
    lat   = -1;
    found = 0;
    for (int k = 1; k <= 20; k++) begin
      if (!found) begin
        @(posedge clock4x); #1;
        if (vpfs_valid === 1'b1) begin
          lat   = k;
          found = 1;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    clusters_valid = 1'b0;
    clear_frame();
    repeat (2) @(posedge clock4x);
    #1;
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", ready); end
    n_cmp++; if (vpfs_out !== '0) begin n_err++; $display("FAIL reset_map: got %0d ones expected 0", $countones(vpfs_out)); end
    n_cmp++; if (vpfs_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", vpfs_valid); end
    n_cmp++; if (n_clusters !== 4'd0) begin n_err++; $display("FAIL reset_ncl: got %0d expected 0", n_clusters); end
    n_cmp++; if (dropped !== 1'b0) begin n_err++; $display("FAIL reset_dropped: got %b expected 0", dropped); end
    reset_n = 1'b1;
    @(posedge clock4x); #1;
  endtask

  task automatic test_single();
    logic [1535:0] exp_map;
    logic [1535:0] held;
    logic rdy;
    int lat;
    clear_frame();
    set_cl(0, 100, 3);
    exp_map = '0;
    for (int b = 100; b <= 103; b++) exp_map[b] = 1'b1;
    run_frame(rdy, lat);
    n_cmp++; if (rdy !== 1'b0) begin n_err++; $display("FAIL single_busy: ready got %b expected 0", rdy); end
    n_cmp++; if (lat != 9) begin n_err++; $display("FAIL single_latency: got %0d expected 9", lat); end
    n_cmp++; if (vpfs_out !== exp_map) begin n_err++; $display("FAIL single_map: got %0d ones expected 4 (bits 100..103)", $countones(vpfs_out)); end
    n_cmp++; if (n_clusters !== 4'd1) begin n_err++; $display("FAIL single_ncl: got %0d expected 1", n_clusters); end
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL single_ready: got %b expected 1", ready); end
    held = vpfs_out;
    @(posedge clock4x); #1;
    n_cmp++; if (vpfs_valid !== 1'b0) begin n_err++; $display("FAIL single_pulse: valid got %b expected 0", vpfs_valid); end
    n_cmp++; if (vpfs_out !== exp_map) begin n_err++; $display("FAIL single_hold: got %0d ones expected 4", $countones(vpfs_out)); end
  endtask

  task automatic test_full_frame();
    logic [1535:0] exp_map;
    logic rdy;
    int lat;
    clear_frame();
    exp_map = '0;
    for (int i = 0; i < 8; i++) begin
      set_cl(i, i * 200, 7);
      for (int b = i * 200; b < i * 200 + 8; b++) exp_map[b] = 1'b1;
    end
    run_frame(rdy, lat);
    n_cmp++; if (lat != 9) begin n_err++; $display("FAIL full_latency: got %0d expected 9", lat); end
    n_cmp++; if (vpfs_out !== exp_map) begin n_err++; $display("FAIL full_map: got %0d ones expected 64 in 8 runs", $countones(vpfs_out)); end
    n_cmp++; if ($countones(vpfs_out) != 64) begin n_err++; $display("FAIL full_popcount: got %0d expected 64", $countones(vpfs_out)); end
    n_cmp++; if (n_clusters !== 4'd8) begin n_err++; $display("FAIL full_ncl: got %0d expected 8", n_clusters); end
  endtask

  task automatic test_clip_overlap();
    logic [1535:0] exp_map;
    logic rdy;
    int lat;
    // Run past the top of the map is clipped.
    clear_frame();
    set_cl(0, 1533, 7);
    exp_map = '0;
    exp_map[1533] = 1'b1; exp_map[1534] = 1'b1; exp_map[1535] = 1'b1;
    run_frame(rdy, lat);
    n_cmp++; if (vpfs_out !== exp_map) begin n_err++; $display("FAIL clip_map: got %0d ones expected 3 (bits 1533..1535)", $countones(vpfs_out)); end
    n_cmp++; if (vpfs_out[2:0] !== 3'b000) begin n_err++; $display("FAIL clip_nowrap: bits[2:0] got %b expected 000", vpfs_out[2:0]); end
    n_cmp++; if (n_clusters !== 4'd1) begin n_err++; $display("FAIL clip_ncl: got %0d expected 1", n_clusters); end
    // Overlapping clusters merge; cluster slots left empty in between.
    clear_frame();
    set_cl(2, 10, 4);
    set_cl(6, 12, 4);
    exp_map = '0;
    for (int b = 10; b <= 16; b++) exp_map[b] = 1'b1;
    run_frame(rdy, lat);
    n_cmp++; if (lat != 9) begin n_err++; $display("FAIL overlap_latency: got %0d expected 9", lat); end
    n_cmp++; if (vpfs_out !== exp_map) begin n_err++; $display("FAIL overlap_map: got %0d ones expected 7 (bits 10..16)", $countones(vpfs_out)); end
    n_cmp++; if (n_clusters !== 4'd2) begin n_err++; $display("FAIL overlap_ncl: got %0d expected 2", n_clusters); end
  endtask

  task automatic test_all_empty();
    logic rdy;
    int lat;
    clear_frame();
    run_frame(rdy, lat);
    n_cmp++; if (lat != 9) begin n_err++; $display("FAIL empty_latency: got %0d expected 9", lat); end
    n_cmp++; if (vpfs_out !== '0) begin n_err++; $display("FAIL empty_map: got %0d ones expected 0", $countones(vpfs_out)); end
    n_cmp++; if (n_clusters !== 4'd0) begin n_err++; $display("FAIL empty_ncl: got %0d expected 0", n_clusters); end
  endtask

  task automatic test_back_to_back();
    logic [1535:0] exp_a;
    logic [1535:0] exp_b;
    int d0;
    int lat;
    bit found;
    clear_frame();
    set_cl(0, 300, 2);
    set_cl(5, 50, 0);
    exp_a = '0;
    exp_a[300] = 1'b1; exp_a[301] = 1'b1; exp_a[302] = 1'b1; exp_a[50] = 1'b1;
    exp_b = '0;
    exp_b[1000] = 1'b1; exp_b[1001] = 1'b1;
    d0 = drop_cnt;

    clusters_valid = 1'b1;
    @(posedge clock4x); #1;                       // E0 accepted
    clusters_valid = 1'b0;
    repeat (2) begin @(posedge clock4x); #1; end  // E1, E2
    clear_frame();
    set_cl(0, 900, 7);
    clusters_valid = 1'b1;
    @(posedge clock4x); #1;                       // E3 dropped
    clusters_valid = 1'b0;
    n_cmp++; if (dropped !== 1'b1) begin n_err++; $display("FAIL bp_drop_e3: got %b expected 1", dropped); end
    repeat (5) begin @(posedge clock4x); #1; end  // E4..E8
    n_cmp++; if (vpfs_valid !== 1'b0) begin n_err++; $display("FAIL bp_early_valid: got %b expected 0", vpfs_valid); end
    clear_frame();
    set_cl(3, 1000, 1);
    clusters_valid = 1'b1;
    @(posedge clock4x); #1;                       // E9: result, strobe dropped
    n_cmp++; if (vpfs_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid_e9: got %b expected 1", vpfs_valid); end
    n_cmp++; if (dropped !== 1'b1) begin n_err++; $display("FAIL bp_drop_e9: got %b expected 1", dropped); end
    n_cmp++; if (vpfs_out !== exp_a) begin n_err++; $display("FAIL bp_map_a: got %0d ones expected 4", $countones(vpfs_out)); end
    n_cmp++; if (n_clusters !== 4'd2) begin n_err++; $display("FAIL bp_ncl_a: got %0d expected 2", n_clusters); end
    @(posedge clock4x); #1;                       // E10 accepted
    clusters_valid = 1'b0;
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL bp_accept_e10: ready got %b expected 0", ready); end
    n_cmp++; if (dropped !== 1'b0) begin n_err++; $display("FAIL bp_nodrop_e10: got %b expected 0", dropped); end
    lat   = -1;
    found = 0;
    for (int k = 1; k <= 20; k++) begin
      if (!found) begin
        @(posedge clock4x); #1;
        if (vpfs_valid === 1'b1) begin lat = k; found = 1; end
      end
    end
    n_cmp++; if (lat != 9) begin n_err++; $display("FAIL bp_latency_b: got %0d expected 9", lat); end
    n_cmp++; if (vpfs_out !== exp_b) begin n_err++; $display("FAIL bp_map_b: got %0d ones expected 2 (bits 1000..1001)", $countones(vpfs_out)); end
    n_cmp++; if (n_clusters !== 4'd1) begin n_err++; $display("FAIL bp_ncl_b: got %0d expected 1", n_clusters); end
    n_cmp++; if (drop_cnt - d0 != 2) begin n_err++; $display("FAIL bp_drop_count: got %0d expected 2", drop_cnt - d0); end
  endtask

  task automatic test_reset_mid_frame();
    logic [1535:0] exp_map;
    logic rdy;
    int lat;
    int seen;
    clear_frame();
    set_cl(0, 20, 5);
    clusters_valid = 1'b1;
    @(posedge clock4x); #1;                       // E0
    clusters_valid = 1'b0;
    repeat (3) begin @(posedge clock4x); #1; end  // E1..E3
    #2 reset_n = 1'b0;                            // asynchronous, before E4
    #1;
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready: got %b expected 1", ready); end
    n_cmp++; if (vpfs_out !== '0) begin n_err++; $display("FAIL rst_mid_map: got %0d ones expected 0", $countones(vpfs_out)); end
    n_cmp++; if (n_clusters !== 4'd0) begin n_err++; $display("FAIL rst_mid_ncl: got %0d expected 0", n_clusters); end
    n_cmp++; if (vpfs_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %b expected 0", vpfs_valid); end
    repeat (2) @(posedge clock4x);
    #1 reset_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clock4x); #1;
      if (vpfs_valid === 1'b1) seen++;
    end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL rst_mid_abort: valid pulses got %0d expected 0", seen); end
    clear_frame();
    set_cl(2, 700, 5);
    exp_map = '0;
    for (int b = 700; b <= 705; b++) exp_map[b] = 1'b1;
    run_frame(rdy, lat);
    n_cmp++; if (lat != 9) begin n_err++; $display("FAIL rst_after_latency: got %0d expected 9", lat); end
    n_cmp++; if (vpfs_out !== exp_map) begin n_err++; $display("FAIL rst_after_map: got %0d ones expected 6 (bits 700..705)", $countones(vpfs_out)); end
    n_cmp++; if (n_clusters !== 4'd1) begin n_err++; $display("FAIL rst_after_ncl: got %0d expected 1", n_clusters); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_single();
    test_full_frame();
    test_clip_overlap();
    test_all_empty();
    test_back_to_back();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
